// File: rtl/mdr_param_core_if.sv
// mdr_param_core_if: operand/op handshake and result bus of the MDR engine.
// The master side drives operands and strobes; the slave side is the core.
interface mdr_param_core_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] data;
   logic [1:0]       op;
   logic             load;
   logic             start;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] remainder;
   logic             ready;
   logic             error;
   logic             load_x;
   logic             load_y;

   modport master (
      output data, op, load, start,
      input  result, remainder, ready, error, load_x, load_y
   );

   modport slave (
      input  data, op, load, start,
      output result, remainder, ready, error, load_x, load_y
   );
endinterface

// File: rtl/mdr_param_core.sv
// mdr_param_core: iterative mul/div/sqrt engine, one bit per clock.
// Square root is compiled in only when MDR_SQRT_EN is defined.
module mdr_param_core #(
   parameter int WIDTH  = 16,
   parameter bit SIGNED = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   mdr_param_core_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] N_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] N_HALF = CW'(WIDTH / 2);
   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_DIV  = 2'b01;
   localparam logic [1:0] OP_SQRT = 2'b10;

   typedef enum logic [2:0] {
      IDLE, WAIT_Y, WAIT_START, RUN, FIX, DONE
   } state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [1:0]       op_q, op_d;
   logic             sx_q, sx_d;
   logic             sy_q, sy_d;
   logic             err_q, err_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             x_neg, y_neg;
   logic [WIDTH-1:0] x_mag, y_mag;
   logic             op_err;
   logic [WIDTH:0]   mac_sum;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH+1:0] div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;
`ifdef MDR_SQRT_EN
   logic [WIDTH+1:0] sr_q, sr_d;
   logic [WIDTH+1:0] sr_sh, sr_nx;
   logic [WIDTH-1:0] sq_rem;
`endif

   assign x_neg = SIGNED && x_q[WIDTH-1];
   assign y_neg = SIGNED && y_q[WIDTH-1];
   assign x_mag = x_neg ? -x_q : x_q;
   assign y_mag = y_neg ? -y_q : y_q;

   // a = product high / partial remainder, b = product low / dividend-quotient
   assign mac_sum  = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : '0);
   assign div_sh   = {a_q, b_q[WIDTH-1]};
   assign div_diff = {1'b0, div_sh} - {2'b00, m_q};
   assign prod_fix = (sx_q ^ sy_q) ? -{a_q, b_q} : {a_q, b_q};
   assign quo_fix  = (sx_q ^ sy_q) ? -b_q : b_q;
   assign rem_fix  = sx_q ? -a_q : a_q;

`ifdef MDR_SQRT_EN
   // Non-restoring root: m holds the root, sr the signed partial remainder
   assign sr_sh  = {sr_q[WIDTH-1:0], 2'b00}
                 + {{WIDTH{1'b0}}, b_q[WIDTH-1:WIDTH-2]};
   assign sr_nx  = sr_q[WIDTH+1] ? sr_sh + {m_q, 2'b11}
                                 : sr_sh - {m_q, 2'b01};
   assign sq_rem = sr_q[WIDTH+1]
                 ? sr_q[WIDTH-1:0] + {m_q[WIDTH-2:0], 1'b1}
                 : sr_q[WIDTH-1:0];
`endif

   always_comb begin
      op_err = 1'b0;
      case (bus.op)
         OP_MUL:  op_err = 1'b0;
         OP_DIV:  op_err = (y_q == '0);
`ifdef MDR_SQRT_EN
         OP_SQRT: op_err = x_neg;
`else
         OP_SQRT: op_err = 1'b1;
`endif
         default: op_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      a_d     = a_q;
      b_d     = b_q;
      m_d     = m_q;
      res_d   = res_q;
      rem_d   = rem_q;
      op_d    = op_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
`ifdef MDR_SQRT_EN
      sr_d    = sr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.load) begin
               x_d     = bus.data;
               state_d = WAIT_Y;
            end
         end
         WAIT_Y: begin
            if (bus.load) begin
               y_d     = bus.data;
               state_d = WAIT_START;
            end
         end
         WAIT_START: begin
            if (bus.start) begin
               op_d = bus.op;
               sx_d = x_neg;
               sy_d = y_neg;
               if (op_err) begin
                  err_d   = 1'b1;
                  res_d   = '0;
                  rem_d   = '0;
                  state_d = DONE;
               end else begin
                  a_d     = '0;
                  state_d = RUN;
                  if (bus.op == OP_SQRT) begin
                     b_d   = x_q;
                     m_d   = '0;
                     cnt_d = N_HALF;
                  end else begin
                     b_d   = x_mag;
                     m_d   = y_mag;
                     cnt_d = N_FULL;
                  end
`ifdef MDR_SQRT_EN
                  sr_d = '0;
`endif
               end
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
               case (op_q)
                  OP_MUL: begin
                     a_d = mac_sum[WIDTH:1];
                     b_d = {mac_sum[0], b_q[WIDTH-1:1]};
                  end
                  OP_DIV: begin
                     if (!div_diff[WIDTH+1]) begin
                        a_d = div_diff[WIDTH-1:0];
                        b_d = {b_q[WIDTH-2:0], 1'b1};
                     end else begin
                        a_d = div_sh[WIDTH-1:0];
                        b_d = {b_q[WIDTH-2:0], 1'b0};
                     end
                  end
`ifdef MDR_SQRT_EN
                  OP_SQRT: begin
                     sr_d = sr_nx;
                     m_d  = {m_q[WIDTH-2:0], ~sr_nx[WIDTH+1]};
                     b_d  = {b_q[WIDTH-3:0], 2'b00};
                  end
`endif
                  default: ;
               endcase
            end
         end
         FIX: begin
            state_d = DONE;
            case (op_q)
               OP_MUL: begin
                  res_d = prod_fix[WIDTH-1:0];
                  rem_d = prod_fix[2*WIDTH-1:WIDTH];
               end
               OP_DIV: begin
                  res_d = quo_fix;
                  rem_d = rem_fix;
               end
`ifdef MDR_SQRT_EN
               OP_SQRT: begin
                  res_d = m_q;
                  rem_d = sq_rem;
               end
`endif
               default: begin
                  res_d = '0;
                  rem_d = '0;
               end
            endcase
         end
         DONE: begin
            if (bus.load) begin
               x_d     = bus.data;
               err_d   = 1'b0;
               state_d = WAIT_Y;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= '0;
         res_q   <= '0;
         rem_q   <= '0;
         op_q    <= '0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef MDR_SQRT_EN
         sr_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         res_q   <= res_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`ifdef MDR_SQRT_EN
         sr_q    <= sr_d;
`endif
      end
   end

   assign bus.result    = res_q;
   assign bus.remainder = rem_q;
   assign bus.ready     = (state_q == DONE);
   assign bus.error     = err_q;
   assign bus.load_x    = (state_q == IDLE) || (state_q == DONE);
   assign bus.load_y    = (state_q == WAIT_Y);
endmodule
